// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// register-index width, EX/MEM M-field bit positions and the NOP word.
package pipeline_ctrl_pkg;

  localparam int REG_W   = 5;
  localparam int STATE_W = 1;

  localparam logic [STATE_W-1:0] RUN      = 1'b0;
  localparam logic [STATE_W-1:0] MEM_WAIT = 1'b1;

  // Bit positions of the memory/branch control group carried in EX/MEM.
  localparam int M_MEMREAD  = 0;
  localparam int M_MEMWRITE = 1;
  localparam int M_BRANCH   = 2;
  localparam int M_W        = 3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic is_mem_access(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs and stage-control outputs exchanged between the
// sequencer (master) and the pipeline datapath (slave).
interface pipeline_ctrl_if import pipeline_ctrl_pkg::*; #(
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] if_id_reg_rs;
  logic [REG_W-1:0] if_id_reg_rt;
  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_reg_rt;
  logic             branch;
  logic             ex_mem_mem_read;
  logic             ex_mem_mem_write;
  logic             dmem_ack;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             id_ex_hold;
  logic             ex_mem_hold;
  logic             mem_wb_bubble;
  logic             dmem_req;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;

  modport master (
    input  if_id_reg_rs, if_id_reg_rt, id_ex_mem_read, id_ex_reg_rt, branch,
           ex_mem_mem_read, ex_mem_mem_write, dmem_ack,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold,
           ex_mem_hold, mem_wb_bubble, dmem_req, stall_cnt, mem_err
  );

  modport slave (
    output if_id_reg_rs, if_id_reg_rt, id_ex_mem_read, id_ex_reg_rt, branch,
           ex_mem_mem_read, ex_mem_mem_write, dmem_ack,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold,
           ex_mem_hold, mem_wb_bubble, dmem_req, stall_cnt, mem_err
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the
// instruction in ID. Writes to $zero never create a dependency.
module pipeline_ctrl_hazard_detect import pipeline_ctrl_pkg::*; (
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_reg_rt,
  input  logic [REG_W-1:0] if_id_reg_rs,
  input  logic [REG_W-1:0] if_id_reg_rt,
  output logic             load_use
);

  always_comb begin
    load_use = id_ex_mem_read
             && (id_ex_reg_rt != '0)
             && ((id_ex_reg_rt == if_id_reg_rs) || (id_ex_reg_rt == if_id_reg_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze FSM with
// timeout, load-use bubble, branch squash, saturating stall counter.
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic             Clock_i,
  input logic             Reset_i,
  pipeline_ctrl_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [STATE_W-1:0] state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               mem_err;

  logic memacc;
  logic load_use;
  logic timeout_hit;
  logic frozen;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic id_ex_hold;
  logic ex_mem_hold;
  logic mem_wb_bubble;
  logic dmem_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  pipeline_ctrl_hazard_detect u_hazard (
    .id_ex_mem_read (bus.id_ex_mem_read),
    .id_ex_reg_rt   (bus.id_ex_reg_rt),
    .if_id_reg_rs   (bus.if_id_reg_rs),
    .if_id_reg_rt   (bus.if_id_reg_rt),
    .load_use       (load_use)
  );

  always_comb begin
    memacc      = is_mem_access(bus.ex_mem_mem_read, bus.ex_mem_mem_write);
    timeout_hit = (state == MEM_WAIT) && !bus.dmem_ack && (wait_cnt == WAIT_LAST);
    // On the timeout cycle the access is dropped and the pipeline advances.
    frozen      = ((state == RUN) && memacc && !bus.dmem_ack)
               || ((state == MEM_WAIT) && !bus.dmem_ack && !timeout_hit);
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_req      = 1'b0;
    if (Reset_i) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      dmem_req = (state == MEM_WAIT) || memacc;
      if (frozen) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (bus.branch) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (!pc_write) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (state == RUN) begin
        if (memacc && !bus.dmem_ack) begin
          state    <= MEM_WAIT;
          wait_cnt <= '0;
        end
      end else begin
        if (bus.dmem_ack) begin
          state <= RUN;
        end else if (timeout_hit) begin
          state   <= RUN;
          mem_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.id_ex_hold    = id_ex_hold;
  assign bus.ex_mem_hold   = ex_mem_hold;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.dmem_req      = dmem_req;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.mem_err       = mem_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for single-cycle behaviour,
// hand sequences for memory wait, priority, timeout and reset corners.
module tb_pipeline_ctrl;

  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 4;

  // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_bubble,
  // id_ex_hold, ex_mem_hold, mem_wb_bubble, dmem_req
  localparam logic [7:0] O_IDLE  = 8'b1100_0000;
  localparam logic [7:0] O_LU    = 8'b0001_0000;
  localparam logic [7:0] O_BR    = 8'b1110_0000;
  localparam logic [7:0] O_ZW    = 8'b1100_0001;
  localparam logic [7:0] O_ZWBR  = 8'b1110_0001;
  localparam logic [7:0] O_FRZ   = 8'b0000_1111;
  localparam logic [7:0] O_LUREQ = 8'b0001_0001;
  localparam logic [7:0] O_RST   = 8'b0001_0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clock_i (clk),
    .Reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ex_rt;
    logic       ex_mr, br, mr, mw, ack;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [7:0] outs();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
            bus.id_ex_hold, bus.ex_mem_hold, bus.mem_wb_bubble, bus.dmem_req};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                       input logic ex_mr, input logic br, input logic mr, input logic mw,
                       input logic ack);
    bus.if_id_reg_rs     = rs;
    bus.if_id_reg_rt     = rt;
    bus.id_ex_reg_rt     = ex_rt;
    bus.id_ex_mem_read   = ex_mr;
    bus.branch           = br;
    bus.ex_mem_mem_read  = mr;
    bus.ex_mem_mem_write = mw;
    bus.dmem_ack         = ack;
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic cyc_chk(input string name, input logic [7:0] exp);
    #2;
    chk(name, {24'd0, outs()}, {24'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_stalls;
    int req_cycles;

    vecs[0]  = '{"idle",         5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[1]  = '{"lu_rs",        5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2]  = '{"lu_zero",      5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[3]  = '{"lu_rt",        5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[4]  = '{"load_nomatch", 5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[5]  = '{"match_noload", 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[6]  = '{"branch",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_BR};
    vecs[7]  = '{"lu_over_br",   5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[8]  = '{"zero_wait_rd", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_ZW};
    vecs[9]  = '{"zero_wait_wr", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_ZWBR};
    vecs[10] = '{"freeze_all",   5'd6, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_FRZ};
    vecs[11] = '{"ack_then_lu",  5'd6, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_LUREQ};

    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("reset_outs", {24'd0, outs()}, {24'd0, O_RST});
    @(posedge clk);
    #1;
    chk("reset_stallcnt", 32'(bus.stall_cnt), 32'd0);
    chk("reset_memerr", 32'(bus.mem_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    exp_stalls = 0;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].ex_rt, vecs[i].ex_mr, vecs[i].br,
            vecs[i].mr, vecs[i].mw, vecs[i].ack);
      if (!vecs[i].exp[7]) exp_stalls++;
      cyc_chk(vecs[i].name, vecs[i].exp);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc_chk("table_back_to_run", O_IDLE);
    chk("table_stallcnt", 32'(bus.stall_cnt), 32'(exp_stalls));

    // Read acknowledged on the fourth cycle of the request.
    do_reset();
    req_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      req_cycles += int'(bus.dmem_req);
      chk("memwait_freeze", {24'd0, outs()}, {24'd0, O_FRZ});
      @(negedge clk);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    req_cycles += int'(bus.dmem_req);
    chk("memwait_ack", {24'd0, outs()}, {24'd0, O_ZW});
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    req_cycles += int'(bus.dmem_req);
    chk("memwait_after", {24'd0, outs()}, {24'd0, O_IDLE});
    chk("memwait_req_cycles", 32'(req_cycles), 32'd4);
    chk("memwait_stallcnt", 32'(bus.stall_cnt), 32'd3);
    @(negedge clk);

    // Freeze masks load-use and branch; they resolve in order after the ack.
    do_reset();
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc_chk("prio_freeze0", O_FRZ);
    cyc_chk("prio_freeze1", O_FRZ);
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc_chk("prio_ack_lu", O_LUREQ);
    drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc_chk("prio_flush", O_BR);
    chk("prio_stallcnt", 32'(bus.stall_cnt), 32'd3);

    // No ack ever: access abandoned on the fifth request cycle.
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) cyc_chk("timeout_freeze", O_FRZ);
    #2;
    chk("timeout_release", {24'd0, outs()}, {24'd0, O_ZW});
    chk("timeout_err_not_yet", 32'(bus.mem_err), 32'd0);
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("timeout_memerr", 32'(bus.mem_err), 32'd1);
    chk("timeout_state_run", {24'd0, outs()}, {24'd0, O_IDLE});
    chk("timeout_stallcnt", 32'(bus.stall_cnt), 32'd4);
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc_chk("sticky_zw", O_ZW);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc_chk("sticky_idle", O_IDLE);
    chk("timeout_sticky", 32'(bus.mem_err), 32'd1);

    // Reset while waiting on memory.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc_chk("rstwait_enter", O_FRZ);
    rst = 1'b1;
    #2;
    chk("rstwait_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("rstwait_outs", {24'd0, outs()}, {24'd0, O_RST});
    @(negedge clk);
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rstwait_run", {24'd0, outs()}, {24'd0, O_IDLE});
    chk("rstwait_stallcnt", 32'(bus.stall_cnt), 32'd0);
    chk("rstwait_memerr", 32'(bus.mem_err), 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
